// File: rtl/lsu_axi_ctrl_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, MemRW codes,
// load funct3 codes, store mask codes, AXI response codes, and the
// misalignment helper used at accept time.
package lsu_axi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } lsu_state_e;

    localparam logic [1:0] MEMRW_NONE  = 2'b00;
    localparam logic [1:0] MEMRW_LOAD  = 2'b01;
    localparam logic [1:0] MEMRW_STORE = 2'b10;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    localparam logic [3:0] WMASK_H = 4'b0011;
    localparam logic [3:0] WMASK_W = 4'b1111;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Access size comes from funct3 for loads and from the byte mask for
    // stores. Undefined load funct3 codes are handled as full words, matching
    // the load extender.
    function automatic logic is_misaligned(input logic [1:0] mem_rw,
                                           input logic [2:0] mem_ext,
                                           input logic [3:0] wmask,
                                           input logic [1:0] addr_lo);
        logic half_s;
        logic word_s;
        half_s = 1'b0;
        word_s = 1'b0;
        case (mem_rw)
            MEMRW_LOAD: begin
                case (mem_ext)
                    FUNCT3_LB, FUNCT3_LBU: begin
                        half_s = 1'b0;
                        word_s = 1'b0;
                    end
                    FUNCT3_LH, FUNCT3_LHU: half_s = 1'b1;
                    default:               word_s = 1'b1;
                endcase
            end
            MEMRW_STORE: begin
                case (wmask)
                    WMASK_H: half_s = 1'b1;
                    WMASK_W: word_s = 1'b1;
                    default: begin
                        half_s = 1'b0;
                        word_s = 1'b0;
                    end
                endcase
            end
            default: begin
                half_s = 1'b0;
                word_s = 1'b0;
            end
        endcase
        return (half_s && addr_lo[0]) || (word_s && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_axi_ctrl_load_ext.sv
// Combinational load aligner/extender.
// Ports:
//   rdata    - raw 32-bit bus read data
//   addr_lo  - low two bits of the byte address (selects the lane)
//   mem_ext  - load funct3 (LB/LH/LW/LBU/LHU)
//   ext_data - lane-0 aligned, sign- or zero-extended result
module lsu_load_ext
    import lsu_axi_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mem_ext,
    output logic [31:0] ext_data
);

    logic [31:0] shifted_s;

    // Move the addressed lane down to bit 0, then extend per funct3.
    always_comb begin
        shifted_s = rdata >> {addr_lo, 3'b000};
        case (mem_ext)
            FUNCT3_LB:  ext_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            FUNCT3_LH:  ext_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            FUNCT3_LBU: ext_data = {24'h000000, shifted_s[7:0]};
            FUNCT3_LHU: ext_data = {16'h0000, shifted_s[15:0]};
            FUNCT3_LW:  ext_data = shifted_s;
            default:    ext_data = shifted_s;
        endcase
    end

endmodule

// File: rtl/lsu_axi_ctrl.sv
// Load/store unit between execute and write-back. Takes one instruction per
// exu_valid/lsu_ready handshake, performs at most one AXI4-Lite access and
// presents the result plus forwarded write-back fields on lsu_valid/wbu_ready.
// Ports:
//   clk, rst (async, active-low)
//   exu_valid/lsu_ready            - upstream handshake
//   MemRW, memAddr, memDataW, wmask, memExt - memory control from execute
//   aluOut_in, WBSel_in, rd_in, RegWrite_in, dnpc_in - forwarded fields
//   AR/R/AW/W/B                    - AXI4-Lite master channels
//   lsu_valid/wbu_ready            - downstream handshake
//   memDataR, aluOut, WBSel, rd, RegWrite, dnpc, lsu_err - registered result
// Every output is a flop; valids are loaded from the next state so they never
// depend combinationally on any ready input.
module lsu_axi_ctrl
    import lsu_axi_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_valid,
    output logic              lsu_ready,
    input  logic [1:0]        MemRW,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memDataW,
    input  logic [3:0]        wmask,
    input  logic [2:0]        memExt,
    input  logic [31:0]       aluOut_in,
    input  logic [1:0]        WBSel_in,
    input  logic [4:0]        rd_in,
    input  logic              RegWrite_in,
    input  logic [31:0]       dnpc_in,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic              lsu_valid,
    input  logic              wbu_ready,
    output logic [DATA_W-1:0] memDataR,
    output logic [31:0]       aluOut,
    output logic [1:0]        WBSel,
    output logic [4:0]        rd,
    output logic              RegWrite,
    output logic [31:0]       dnpc,
    output logic              lsu_err
);

    lsu_state_e        state_r, state_s;
    logic              aw_done_r, aw_done_s;
    logic              w_done_r, w_done_s;
    logic              accept_s;
    logic              misalign_s;
    logic [31:0]       ext_data_s;
    logic [1:0]        addr_lo_r;
    logic [2:0]        mem_ext_r;

    logic              lsu_ready_r, arvalid_r, rready_r, awvalid_r, wvalid_r;
    logic              bready_r, lsu_valid_r, lsu_err_r, reg_write_r;
    logic [ADDR_W-1:0] araddr_r, awaddr_r;
    logic [DATA_W-1:0] wdata_r, mem_data_r;
    logic [3:0]        wstrb_r;
    logic [31:0]       alu_out_r, dnpc_r;
    logic [1:0]        wb_sel_r;
    logic [4:0]        rd_r;

    assign accept_s   = exu_valid && lsu_ready_r;
    assign misalign_s = is_misaligned(MemRW, memExt, wmask, memAddr[1:0]);

    lsu_load_ext u_load_ext (
        .rdata    (rdata),
        .addr_lo  (addr_lo_r),
        .mem_ext  (mem_ext_r),
        .ext_data (ext_data_s)
    );

    // Next-state logic, including the sticky AW/W completion flags.
    always_comb begin
        state_s   = state_r;
        aw_done_s = aw_done_r;
        w_done_s  = w_done_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    aw_done_s = 1'b0;
                    w_done_s  = 1'b0;
                    if (misalign_s) begin
                        state_s = DONE;
                    end else begin
                        case (MemRW)
                            MEMRW_LOAD:  state_s = RD_ADDR;
                            MEMRW_STORE: state_s = WR_REQ;
                            MEMRW_NONE:  state_s = DONE;
                            default:     state_s = DONE;
                        endcase
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    state_s = RD_DATA;
                end else begin
                    state_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    state_s = DONE;
                end else begin
                    state_s = RD_DATA;
                end
            end
            WR_REQ: begin
                // A valid is only high while its done flag is clear, so a
                // stale ready after completion cannot re-trigger.
                aw_done_s = aw_done_r || (awvalid_r && awready);
                w_done_s  = w_done_r || (wvalid_r && wready);
                if (aw_done_s && w_done_s) begin
                    state_s = WR_RESP;
                end else begin
                    state_s = WR_REQ;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    state_s = DONE;
                end else begin
                    state_s = WR_RESP;
                end
            end
            DONE: begin
                if (wbu_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and handshake outputs, loaded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            lsu_ready_r <= 1'b1;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            lsu_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            aw_done_r   <= aw_done_s;
            w_done_r    <= w_done_s;
            lsu_ready_r <= (state_s == IDLE);
            arvalid_r   <= (state_s == RD_ADDR);
            rready_r    <= (state_s == RD_DATA);
            awvalid_r   <= (state_s == WR_REQ) && !aw_done_s;
            wvalid_r    <= (state_s == WR_REQ) && !w_done_s;
            bready_r    <= (state_s == WR_RESP);
            lsu_valid_r <= (state_s == DONE);
        end
    end

    // Data path: capture at accept, then update with the bus response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            araddr_r    <= '0;
            awaddr_r    <= '0;
            wdata_r     <= '0;
            wstrb_r     <= 4'b0000;
            mem_data_r  <= '0;
            lsu_err_r   <= 1'b0;
            alu_out_r   <= 32'h0000_0000;
            wb_sel_r    <= 2'b00;
            rd_r        <= 5'd0;
            reg_write_r <= 1'b0;
            dnpc_r      <= 32'h0000_0000;
            addr_lo_r   <= 2'b00;
            mem_ext_r   <= 3'b000;
        end else if (accept_s) begin
            araddr_r    <= memAddr;
            awaddr_r    <= memAddr;
            wdata_r     <= memDataW << {memAddr[1:0], 3'b000};
            wstrb_r     <= wmask << memAddr[1:0];
            mem_data_r  <= '0;
            lsu_err_r   <= misalign_s;
            alu_out_r   <= aluOut_in;
            wb_sel_r    <= WBSel_in;
            rd_r        <= rd_in;
            reg_write_r <= RegWrite_in;
            dnpc_r      <= dnpc_in;
            addr_lo_r   <= memAddr[1:0];
            mem_ext_r   <= memExt;
        end else if ((state_r == RD_DATA) && rvalid) begin
            mem_data_r  <= ext_data_s;
            lsu_err_r   <= (rresp != AXI_RESP_OKAY);
        end else if ((state_r == WR_RESP) && bvalid) begin
            lsu_err_r   <= (bresp != AXI_RESP_OKAY);
        end else begin
            lsu_err_r   <= lsu_err_r;
        end
    end

    assign lsu_ready = lsu_ready_r;
    assign araddr    = araddr_r;
    assign arvalid   = arvalid_r;
    assign rready    = rready_r;
    assign awaddr    = awaddr_r;
    assign awvalid   = awvalid_r;
    assign wdata     = wdata_r;
    assign wstrb     = wstrb_r;
    assign wvalid    = wvalid_r;
    assign bready    = bready_r;
    assign lsu_valid = lsu_valid_r;
    assign memDataR  = mem_data_r;
    assign aluOut    = alu_out_r;
    assign WBSel     = wb_sel_r;
    assign rd        = rd_r;
    assign RegWrite  = reg_write_r;
    assign dnpc      = dnpc_r;
    assign lsu_err   = lsu_err_r;

endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// Scoreboard bench for lsu_axi_ctrl with a small configurable AXI slave.
module tb_lsu_axi_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, lsu_ready;
    logic [1:0]  MemRW;
    logic [31:0] memAddr, memDataW;
    logic [3:0]  wmask;
    logic [2:0]  memExt;
    logic [31:0] aluOut_in, dnpc_in;
    logic [1:0]  WBSel_in;
    logic [4:0]  rd_in;
    logic        RegWrite_in;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;
    logic        lsu_valid, wbu_ready;
    logic [31:0] memDataR, aluOut, dnpc;
    logic [1:0]  WBSel;
    logic [4:0]  rd;
    logic        RegWrite, lsu_err;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [31:0] alu;
        logic [4:0]  rdn;
        logic [1:0]  wbsel;
        logic        regw;
        logic [31:0] dnpc;
    } exp_t;

    exp_t sb_q[$];
    int   check_cnt = 0;
    int   error_cnt = 0;

    // slave controls
    logic [31:0] mem_rdata = 32'h0;
    logic [1:0]  mem_rresp = 2'b00;
    logic [1:0]  mem_bresp = 2'b00;
    logic        rd_en = 1'b1;
    int          aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, viol_cnt = 0;
    logic        ar_pend = 1'b0, aw_pend = 1'b0, w_pend = 1'b0;
    logic [31:0] cap_wdata = 32'h0, cap_awaddr = 32'h0;
    logic [3:0]  cap_wstrb = 4'h0;

    always #5 clk = ~clk;

    lsu_axi_ctrl dut (
        .clk(clk), .rst(rst), .exu_valid(exu_valid), .lsu_ready(lsu_ready),
        .MemRW(MemRW), .memAddr(memAddr), .memDataW(memDataW), .wmask(wmask),
        .memExt(memExt), .aluOut_in(aluOut_in), .WBSel_in(WBSel_in),
        .rd_in(rd_in), .RegWrite_in(RegWrite_in), .dnpc_in(dnpc_in),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .lsu_valid(lsu_valid), .wbu_ready(wbu_ready), .memDataR(memDataR),
        .aluOut(aluOut), .WBSel(WBSel), .rd(rd), .RegWrite(RegWrite),
        .dnpc(dnpc), .lsu_err(lsu_err)
    );

    // Slave responses: zero-wait reads, configurable AW/W ready delays.
    assign arready = 1'b1;
    assign rdata   = mem_rdata;
    assign rresp   = mem_rresp;
    assign rvalid  = rready && rd_en;
    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid && (w_wait >= w_delay);
    assign bvalid  = bready;
    assign bresp   = mem_bresp;

    // Handshake counting, write capture and valid-stability monitoring.
    always @(posedge clk) begin
        aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
        w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
        if (!rst) begin
            ar_pend <= 1'b0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else begin
            if (arvalid && arready) ar_hs <= ar_hs + 1;
            if (awvalid && awready) begin
                aw_hs      <= aw_hs + 1;
                cap_awaddr <= awaddr;
            end
            if (wvalid && wready) begin
                w_hs      <= w_hs + 1;
                cap_wdata <= wdata;
                cap_wstrb <= wstrb;
            end
            if (bvalid && bready) b_hs <= b_hs + 1;
            if ((ar_pend && !arvalid) || (aw_pend && !awvalid) || (w_pend && !wvalid))
                viol_cnt <= viol_cnt + 1;
            ar_pend <= arvalid && !arready;
            aw_pend <= awvalid && !awready;
            w_pend  <= wvalid && !wready;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] rw, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] wm, input logic [2:0] ext,
                          input logic [31:0] alu, input logic [4:0] rdn,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input int hold);
        exp_t e, o;
        int   lat;
        bit   got;
        @(negedge clk);
        check_eq({tag, "_rdy"}, 32'(lsu_ready), 32'd1);
        MemRW = rw; memAddr = addr; memDataW = wd; wmask = wm; memExt = ext;
        aluOut_in = alu; rd_in = rdn; WBSel_in = rdn[1:0]; RegWrite_in = ~rdn[0];
        dnpc_in = alu ^ 32'h8000_0004;
        e.data = exp_data; e.err = exp_err; e.alu = alu; e.rdn = rdn;
        e.wbsel = rdn[1:0]; e.regw = ~rdn[0]; e.dnpc = alu ^ 32'h8000_0004;
        sb_q.push_back(e);
        exu_valid = 1'b1;
        @(posedge clk);
        #1;
        exu_valid = 1'b0; MemRW = 2'b00; memAddr = 32'h0; aluOut_in = 32'hDEAD_BEEF;
        rd_in = 5'd0; dnpc_in = 32'h0; memDataW = 32'h0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            got = lsu_valid;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (!got) begin
            o = sb_q.pop_front();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check_eq({tag, "_hold_vr"}, 32'({lsu_valid, lsu_ready}), 32'd2);
            check_eq({tag, "_hold_alu"}, aluOut, alu);
            @(negedge clk);
        end
        wbu_ready = 1'b1;
        o = sb_q.pop_front();
        check_eq({tag, "_data"}, memDataR, o.data);
        check_eq({tag, "_err"}, 32'(lsu_err), 32'(o.err));
        check_eq({tag, "_alu"}, aluOut, o.alu);
        check_eq({tag, "_rd"}, 32'(rd), 32'(o.rdn));
        check_eq({tag, "_wbsel"}, 32'(WBSel), 32'(o.wbsel));
        check_eq({tag, "_regw"}, 32'(RegWrite), 32'(o.regw));
        check_eq({tag, "_dnpc"}, dnpc, o.dnpc);
        @(posedge clk);
        #1;
        wbu_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_ret"}, 32'({lsu_valid, lsu_ready}), 32'd1);
    endtask

    int ar0, aw0, w0, b0, n;

    initial begin
        rst = 1'b1; exu_valid = 1'b0; wbu_ready = 1'b0; MemRW = 2'b00;
        memAddr = 32'h0; memDataW = 32'h0; wmask = 4'h0; memExt = 3'b000;
        aluOut_in = 32'h0; WBSel_in = 2'b00; rd_in = 5'd0; RegWrite_in = 1'b0;
        dnpc_in = 32'h0;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready, lsu_valid}), 32'd0);
        check_eq("rst_ready", 32'(lsu_ready), 32'd1);
        check_eq("rst_data", memDataR, 32'h0);
        check_eq("rst_err", 32'(lsu_err), 32'd0);
        check_eq("rst_fwd", aluOut | dnpc | 32'(wstrb) | wdata | araddr, 32'h0);
        rst = 1'b1;

        // loads
        mem_rdata = 32'h80FF_1234; ar0 = ar_hs;
        run_op("lb", 2'b01, 32'h8000_0003, 32'h0, 4'h0, 3'b000, 32'h100, 5'd1, 32'hFFFF_FF80, 1'b0, 3, 0);
        check_eq("lb_ar_cnt", 32'(ar_hs - ar0), 32'd1);
        mem_rdata = 32'hBEEF_0000;
        run_op("lhu", 2'b01, 32'h8000_0002, 32'h0, 4'h0, 3'b101, 32'h200, 5'd2, 32'h0000_BEEF, 1'b0, 3, 0);
        run_op("lh", 2'b01, 32'h8000_0002, 32'h0, 4'h0, 3'b001, 32'h300, 5'd3, 32'hFFFF_BEEF, 1'b0, 3, 0);

        // SB with AW completing two cycles after W
        aw_delay = 2; w_delay = 0; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        run_op("sb", 2'b10, 32'h8000_0001, 32'h0000_00AB, 4'b0001, 3'b000, 32'h400, 5'd4, 32'h0, 1'b0, 5, 0);
        check_eq("sb_wdata", cap_wdata, 32'h0000_AB00);
        check_eq("sb_wstrb", 32'(cap_wstrb), 32'h2);
        check_eq("sb_awaddr", cap_awaddr, 32'h8000_0001);
        check_eq("sb_hs", 32'({4'(aw_hs - aw0), 4'(w_hs - w0), 4'(b_hs - b0)}), 32'h111);

        // SH with W completing after AW
        aw_delay = 0; w_delay = 1; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        run_op("sh", 2'b10, 32'h8000_0012, 32'h0000_CAFE, 4'b0011, 3'b000, 32'h500, 5'd6, 32'h0, 1'b0, 4, 0);
        check_eq("sh_wdata", cap_wdata, 32'hCAFE_0000);
        check_eq("sh_wstrb", 32'(cap_wstrb), 32'hC);
        check_eq("sh_hs", 32'({4'(aw_hs - aw0), 4'(w_hs - w0), 4'(b_hs - b0)}), 32'h111);

        // SW zero-wait
        w_delay = 0;
        run_op("sw", 2'b10, 32'h8000_0004, 32'h1122_3344, 4'b1111, 3'b000, 32'h600, 5'd8, 32'h0, 1'b0, 3, 0);
        check_eq("sw_wdata", cap_wdata, 32'h1122_3344);
        check_eq("sw_wstrb", 32'(cap_wstrb), 32'hF);

        // misaligned word load, misaligned half store: no bus activity
        ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
        mem_rdata = 32'h5555_AAAA;
        run_op("lw_mis", 2'b01, 32'h8000_0002, 32'h0, 4'h0, 3'b010, 32'h700, 5'd9, 32'h0, 1'b1, 1, 0);
        run_op("sh_mis", 2'b10, 32'h8000_0001, 32'h0000_1111, 4'b0011, 3'b000, 32'h780, 5'd10, 32'h0, 1'b1, 1, 0);
        check_eq("mis_bus", 32'({4'(ar_hs - ar0), 4'(aw_hs - aw0), 4'(w_hs - w0)}), 32'h0);

        // non-memory with WBU back-pressure, and MemRW=11
        ar0 = ar_hs; aw0 = aw_hs;
        run_op("nop", 2'b00, 32'h8000_0000, 32'h0, 4'h0, 3'b000, 32'h0000_1234, 5'd5, 32'h0, 1'b0, 1, 4);
        run_op("rw11", 2'b11, 32'h8000_0000, 32'h0, 4'hF, 3'b010, 32'h5555, 5'd7, 32'h0, 1'b0, 1, 0);
        check_eq("none_bus", 32'({4'(ar_hs - ar0), 4'(aw_hs - aw0)}), 32'h0);

        // error responses
        mem_rresp = 2'b10; mem_rdata = 32'hCAFE_F00D;
        run_op("lw_slverr", 2'b01, 32'h8000_0008, 32'h0, 4'h0, 3'b010, 32'h800, 5'd11, 32'hCAFE_F00D, 1'b1, 3, 0);
        mem_rresp = 2'b00; mem_bresp = 2'b11;
        run_op("sw_decerr", 2'b10, 32'h8000_000C, 32'h0BAD_0BAD, 4'b1111, 3'b000, 32'h900, 5'd12, 32'h0, 1'b1, 3, 0);
        mem_bresp = 2'b00;

        // reset pulsed while waiting in RD_DATA
        rd_en = 1'b0;
        @(negedge clk);
        MemRW = 2'b01; memAddr = 32'h8000_0000; memExt = 3'b010; exu_valid = 1'b1;
        @(posedge clk);
        #1;
        exu_valid = 1'b0; MemRW = 2'b00;
        n = 0;
        while (!rready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rstmid_rready", 32'(rready), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("rstmid_valids", 32'({arvalid, awvalid, wvalid, rready, bready, lsu_valid}), 32'd0);
        check_eq("rstmid_ready", 32'(lsu_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1; rd_en = 1'b1;
        mem_rdata = 32'h0000_A500;
        run_op("lbu_after", 2'b01, 32'h8000_0001, 32'h0, 4'h0, 3'b100, 32'hA00, 5'd13, 32'h0000_00A5, 1'b0, 3, 0);

        check_eq("valid_stable", 32'(viol_cnt), 32'd0);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
